// File: rtl/adxl345_pkg.sv
// Shared constants, types and helpers for the ADXL345 SPI register-map responder.
package adxl345_pkg;

    localparam logic [5:0] ADDR_DEVID  = 6'h00;
    localparam logic [5:0] ADDR_DATAX0 = 6'h32;
    localparam logic [5:0] ADDR_DATAX1 = 6'h33;
    localparam logic [5:0] ADDR_DATAY0 = 6'h34;
    localparam logic [5:0] ADDR_DATAY1 = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0 = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1 = 6'h37;

    localparam logic [7:0] DEVID_VALUE = 8'hE5;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } spi_state_e;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } axis_sample_t;

    // DEVID and the axis data block cannot be written from the SPI side.
    function automatic logic reg_writable(input logic [5:0] addr);
        return (addr != ADDR_DEVID) && !((addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1));
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers plus rise/fall detectors for the SPI pins.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic sclk_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_o,
    output logic cs_rise_o,
    output logic cs_fall_o,
    output logic mosi_o,
    output logic mosi_rise_o,
    output logic mosi_fall_o
);

    // Bit order {mosi, cs, spi_clk}; reset to the bus idle levels.
    localparam logic [2:0] PIN_IDLE = 3'b011;

    logic [2:0] pins;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] sync3_q;
    logic [2:0] rise;
    logic [2:0] fall;

    assign pins = {mosi_i, cs_i, spi_clk_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
            sync3_q <= PIN_IDLE;
        end else begin
            sync1_q <= pins;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Edge pulses are visible after two flops and consumed at the third clock.
    always_comb begin
        rise = sync2_q & ~sync3_q;
        fall = ~sync2_q & sync3_q;
    end

    assign sclk_o      = sync2_q[0];
    assign sclk_rise_o = rise[0];
    assign sclk_fall_o = fall[0];
    assign cs_o        = sync2_q[1];
    assign cs_rise_o   = rise[1];
    assign cs_fall_o   = fall[1];
    assign mosi_o      = sync2_q[2];
    assign mosi_rise_o = rise[2];
    assign mosi_fall_o = fall[2];

endmodule

// File: rtl/adxl345_spi_responder.sv
// SPI mode-3 responder emulating the ADXL345 register interface, with
// atomic, between-transaction loading of axis samples into DATAX0..DATAZ1.
module adxl345_spi_responder
    import adxl345_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        reg_wr_stb,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);

    logic sclk_lvl_unused;
    logic mosi_rise_unused;
    logic mosi_fall_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;
    logic mosi_lvl;

    spi_pin_sync u_pin_sync (
        .clk         (clk),
        .rst         (rst),
        .spi_clk_i   (spi_clk),
        .cs_i        (CS),
        .mosi_i      (MOSI),
        .sclk_o      (sclk_lvl_unused),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_o        (cs_lvl),
        .cs_rise_o   (cs_rise),
        .cs_fall_o   (cs_fall),
        .mosi_o      (mosi_lvl),
        .mosi_rise_o (mosi_rise_unused),
        .mosi_fall_o (mosi_fall_unused)
    );

    spi_state_e   state_q;
    logic [2:0]   bit_cnt_q;
    logic [6:0]   shift_in_q;
    logic [7:0]   shift_out_q;
    logic         rw_q;
    logic         mb_q;
    logic [5:0]   addr_q;
    logic         miso_q;
    logic         wr_stb_q;
    logic [5:0]   wr_addr_q;
    logic [7:0]   wr_data_q;
    logic [7:0]   regs_q [64];
    axis_sample_t shadow_q;
    logic         pending_q;

    logic [7:0]   rx_byte_d;
    logic         byte_done_d;
    logic [5:0]   addr_next_d;
    logic [5:0]   rd_addr_d;
    logic [7:0]   rd_data_d;
    logic         wr_en_d;

    always_comb begin
        rx_byte_d   = {shift_in_q, mosi_lvl};
        byte_done_d = sclk_rise && (bit_cnt_q == 3'd7);
        addr_next_d = mb_q ? addr_q + 6'd1 : addr_q;
        // The byte boundary preloads the next read byte: from the command's
        // address when leaving CMD, otherwise from the advanced address.
        rd_addr_d   = (state_q == CMD) ? rx_byte_d[5:0] : addr_next_d;
        rd_data_d   = (rd_addr_d == ADDR_DEVID) ? DEVID_VALUE : regs_q[rd_addr_d];
        wr_en_d     = (state_q == DATA) && !cs_rise && byte_done_d && !rw_q
                      && reg_writable(addr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            rw_q        <= 1'b0;
            mb_q        <= 1'b0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    if (cs_fall) begin
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            miso_q <= 1'b0;
                        end
                        if (sclk_rise) begin
                            shift_in_q <= rx_byte_d[6:0];
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (byte_done_d) begin
                                rw_q        <= rx_byte_d[7];
                                mb_q        <= rx_byte_d[6];
                                addr_q      <= rx_byte_d[5:0];
                                shift_out_q <= rd_data_d;
                                state_q     <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            miso_q      <= rw_q & shift_out_q[7];
                            shift_out_q <= {shift_out_q[6:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            shift_in_q <= rx_byte_d[6:0];
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (byte_done_d) begin
                                addr_q      <= addr_next_d;
                                shift_out_q <= rd_data_d;
                            end
                        end
                        if (wr_en_d) begin
                            wr_stb_q  <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= rx_byte_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 64; i++) begin
                regs_q[i] <= '0;
            end
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (pending_q && (state_q == IDLE)) begin
                regs_q[ADDR_DATAX0] <= shadow_q.x[7:0];
                regs_q[ADDR_DATAX1] <= shadow_q.x[15:8];
                regs_q[ADDR_DATAY0] <= shadow_q.y[7:0];
                regs_q[ADDR_DATAY1] <= shadow_q.y[15:8];
                regs_q[ADDR_DATAZ0] <= shadow_q.z[7:0];
                regs_q[ADDR_DATAZ1] <= shadow_q.z[15:8];
                pending_q           <= 1'b0;
            end
            // A strobe in the same cycle as the copy keeps the newer sample pending.
            if (sample_valid) begin
                shadow_q  <= '{x: sample_x, y: sample_y, z: sample_z};
                pending_q <= 1'b1;
            end
            if (wr_en_d) begin
                regs_q[addr_q] <= rx_byte_d;
            end
        end
    end

    assign MISO        = miso_q;
    assign reg_wr_stb  = wr_stb_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = ~cs_lvl;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Directed bench for adxl345_spi_responder: an SPI mode-3 master drives fixed vectors.
module tb_adxl345_spi_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        CS;
    logic        MOSI;
    logic        MISO;
    logic        sample_valid;
    logic [15:0] sample_x;
    logic [15:0] sample_y;
    logic [15:0] sample_z;
    logic        reg_wr_stb;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned stb_cycles = 0;
    logic [5:0]  last_addr = '0;
    logic [7:0]  last_data = '0;

    adxl345_spi_responder dut (
        .clk          (clk),
        .rst          (rst),
        .spi_clk      (spi_clk),
        .CS           (CS),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .sample_valid (sample_valid),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .reg_wr_stb   (reg_wr_stb),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_stb) begin
            stb_cycles = stb_cycles + 1;
            last_addr  = reg_wr_addr;
            last_data  = reg_wr_data;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Master drives MOSI on the falling edge and samples MISO just before the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_clk = 1'b0;
            MOSI    = tx[i];
            wait_clk(HALF);
            rx[i]   = MISO;
            spi_clk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] rx;
        spi_bits(tx, 8, rx);
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        logic [7:0] rx;
        spi_bits(8'h00, 8, rx);
        check(tag, rx, exp);
    endtask

    task automatic cs_begin();
        CS = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_end();
        wait_clk(4);
        CS   = 1'b1;
        MOSI = 1'b0;
        wait_clk(10);
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        sample_x     = x;
        sample_y     = y;
        sample_z     = z;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
        wait_clk(3);
    endtask

    initial begin
        int unsigned stb0;
        rst          = 1'b1;
        spi_clk      = 1'b1;
        CS           = 1'b1;
        MOSI         = 1'b0;
        sample_valid = 1'b0;
        sample_x     = '0;
        sample_y     = '0;
        sample_z     = '0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);

        check("rst_miso", 8'(MISO), 8'h00);
        check("rst_stb", 8'(reg_wr_stb), 8'h00);
        check("rst_wr_addr", 8'(reg_wr_addr), 8'h00);
        check("rst_wr_data", reg_wr_data, 8'h00);
        check("rst_busy", 8'(busy), 8'h00);

        // DEVID single read
        stb0 = stb_cycles;
        cs_begin();
        check("busy_low_cs", 8'(busy), 8'h01);
        send(8'h80);
        rd("devid", 8'hE5);
        cs_end();
        check("busy_idle", 8'(busy), 8'h00);
        check("miso_idle", 8'(MISO), 8'h00);
        check("devid_no_stb", 8'(stb_cycles - stb0), 8'h00);

        // Sample load while idle, then 6-byte burst from DATAX0
        pulse_sample(16'h1234, 16'hFF80, 16'h0001);
        cs_begin();
        send(8'hF2);
        rd("s1_x0", 8'h34);
        rd("s1_x1", 8'h12);
        rd("s1_y0", 8'h80);
        rd("s1_y1", 8'hFF);
        rd("s1_z0", 8'h01);
        rd("s1_z1", 8'h00);
        cs_end();

        // Single write and read-back
        stb0 = stb_cycles;
        cs_begin();
        send(8'h2D);
        send(8'hA5);
        cs_end();
        check("wr_stb_count", 8'(stb_cycles - stb0), 8'h01);
        check("wr_addr", 8'(last_addr), 8'h2D);
        check("wr_data", last_data, 8'hA5);
        cs_begin();
        send(8'hAD);
        rd("rdback_2d", 8'hA5);
        cs_end();

        // Multi-byte write wrapping 0x3F -> 0x00 (DEVID ignored)
        stb0 = stb_cycles;
        cs_begin();
        send(8'h7F);
        send(8'h11);
        send(8'h22);
        cs_end();
        check("wrap_stb_count", 8'(stb_cycles - stb0), 8'h01);
        check("wrap_addr", 8'(last_addr), 8'h3F);
        check("wrap_data", last_data, 8'h11);
        cs_begin();
        send(8'hFF);
        rd("wrap_rd_3f", 8'h11);
        rd("wrap_rd_00", 8'hE5);
        cs_end();

        // New sample arriving mid-burst must not disturb the in-flight bytes
        cs_begin();
        send(8'hF2);
        rd("mid_x0", 8'h34);
        rd("mid_x1", 8'h12);
        pulse_sample(16'hABCD, 16'h5678, 16'h9ABC);
        rd("mid_y0", 8'h80);
        rd("mid_y1", 8'hFF);
        rd("mid_z0", 8'h01);
        rd("mid_z1", 8'h00);
        cs_end();
        cs_begin();
        send(8'hF2);
        rd("s2_x0", 8'hCD);
        rd("s2_x1", 8'hAB);
        rd("s2_y0", 8'h78);
        rd("s2_y1", 8'h56);
        rd("s2_z0", 8'hBC);
        rd("s2_z1", 8'h9A);
        cs_end();

        // Write to a read-only data register is dropped; MB=0 repeats the address
        stb0 = stb_cycles;
        cs_begin();
        send(8'h32);
        send(8'h77);
        cs_end();
        check("ro_no_stb", 8'(stb_cycles - stb0), 8'h00);
        cs_begin();
        send(8'hB2);
        rd("nomb_rd0", 8'hCD);
        rd("nomb_rd1", 8'hCD);
        cs_end();

        // Partial data byte aborted by CS rising
        stb0 = stb_cycles;
        begin
            logic [7:0] rx;
            cs_begin();
            send(8'h2D);
            spi_bits(8'h3C, 4, rx);
            cs_end();
        end
        check("partial_no_stb", 8'(stb_cycles - stb0), 8'h00);
        cs_begin();
        send(8'hAD);
        rd("partial_rdback", 8'hA5);
        cs_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
